// File: rtl/project_spi_pkg.sv
// Shared types and constants for the SPI register bridge.
package project_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int   FRAME_BYTE_BITS = 8;
    localparam logic RW_WRITE        = 1'b1;

endpackage

// File: rtl/project_spi_register_bridge_if.sv
// SPI pin and register-file port bundle; the bridge connects through the slave modport.
interface project_spi_register_bridge_if
    import project_spi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6
);
    logic                       i_spi_sclk;
    logic                       i_spi_cs_n;
    logic                       i_spi_mosi;
    logic                       o_spi_miso;
    logic                       o_write_en;
    logic [ADDRESS_WIDTH-1:0]   o_address;
    logic [FRAME_BYTE_BITS-1:0] o_wdata;
    logic [FRAME_BYTE_BITS-1:0] i_rdata;
    logic                       o_frame_error;

    modport slave (
        input  i_spi_sclk, i_spi_cs_n, i_spi_mosi, i_rdata,
        output o_spi_miso, o_write_en, o_address, o_wdata, o_frame_error
    );

    modport master (
        output i_spi_sclk, i_spi_cs_n, i_spi_mosi, i_rdata,
        input  o_spi_miso, o_write_en, o_address, o_wdata, o_frame_error
    );
endinterface

// File: rtl/project_spi_sync_edge.sv
// N-stage synchroniser with rise/fall detection against the previous synced value.
module project_spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_chain <= {STAGES{RESET_VAL}};
            r_prev  <= RESET_VAL;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;
endmodule

// File: rtl/project_spi_register_bridge.sv
// SPI mode-0 slave that turns {rw/addr, data} frames into register-file writes and reads.
// Optional multi-byte bursts with address auto-increment: define PROJECT_SPI_BURST_EN.
module project_spi_register_bridge
    import project_spi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int SYNC_STAGES   = 2
) (
    input logic                          i_clk,
    input logic                          i_reset,
    project_spi_register_bridge_if.slave bus
);
    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_mosi;
    logic w_unused;

    logic [SYNC_STAGES-1:0]     r_mosi_sync;
    state_t                     r_state;
    logic [2:0]                 r_bit_cnt;
    logic [FRAME_BYTE_BITS-1:0] r_rx;
    logic [FRAME_BYTE_BITS-1:0] r_tx;
    logic [FRAME_BYTE_BITS-1:0] r_wdata;
    logic [ADDRESS_WIDTH-1:0]   r_address;
    logic                       r_rw;
    logic                       r_cmd_p1, r_cmd_p2, r_byte_p1;
    logic                       r_miso, r_write_en, r_frame_error;
`ifdef PROJECT_SPI_BURST_EN
    logic                       r_byte_p2;
`endif

    project_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(bus.i_spi_sclk),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    project_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(bus.i_spi_cs_n),
        .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    // MOSI has the same depth as SCLK so the synced bit lines up with the synced rising edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_mosi_sync <= '0;
        else         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.i_spi_mosi};
    end
    assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
    assign w_unused = &{1'b0, w_sclk_sync, w_cs_rise};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_rx          <= '0;
            r_tx          <= '0;
            r_wdata       <= '0;
            r_address     <= '0;
            r_rw          <= 1'b0;
            r_cmd_p1      <= 1'b0;
            r_cmd_p2      <= 1'b0;
            r_byte_p1     <= 1'b0;
            r_miso        <= 1'b0;
            r_write_en    <= 1'b0;
            r_frame_error <= 1'b0;
`ifdef PROJECT_SPI_BURST_EN
            r_byte_p2     <= 1'b0;
`endif
        end else begin
            r_write_en    <= 1'b0;
            r_frame_error <= 1'b0;
            r_cmd_p1      <= 1'b0;
            r_cmd_p2      <= r_cmd_p1;
            r_byte_p1     <= 1'b0;

            // Post-byte pipeline: address/rw, then read data fetch from the new address.
            if (r_cmd_p1) begin
                r_address <= r_rx[ADDRESS_WIDTH-1:0];
                r_rw      <= r_rx[FRAME_BYTE_BITS-1];
            end
            if (r_cmd_p2) r_tx <= bus.i_rdata;
            if (r_byte_p1 && r_rw == RW_WRITE) begin
                r_write_en <= 1'b1;
                r_wdata    <= r_rx;
            end
`ifdef PROJECT_SPI_BURST_EN
            r_byte_p2 <= r_byte_p1;
            if (r_byte_p1 && r_rw != RW_WRITE) r_address <= r_address + ADDRESS_WIDTH'(1);
            if (r_byte_p2 && r_rw == RW_WRITE) r_address <= r_address + ADDRESS_WIDTH'(1);
            if (r_byte_p2 && r_rw != RW_WRITE) r_tx <= bus.i_rdata;
`endif

            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    r_miso    <= 1'b0;
                    if (w_cs_fall) r_state <= CMD;
                end
                CMD: begin
                    if (w_sclk_rise) begin
                        r_rx      <= {r_rx[FRAME_BYTE_BITS-2:0], w_mosi};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_cmd_p1 <= 1'b1;
                            r_state  <= DATA;
                        end
                    end else if (w_cs_sync) begin
                        r_frame_error <= (r_bit_cnt != 3'd0);
                        r_state       <= IDLE;
                    end
                end
                DATA: begin
                    // A rising edge wins over a simultaneous cs_n release so the last bit still lands.
                    if (w_sclk_rise) begin
                        r_rx      <= {r_rx[FRAME_BYTE_BITS-2:0], w_mosi};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_byte_p1 <= 1'b1;
`ifndef PROJECT_SPI_BURST_EN
                            r_state   <= DONE;
                            r_miso    <= 1'b0;
`endif
                        end
                    end else if (w_sclk_fall) begin
                        if (r_rw != RW_WRITE) begin
                            r_miso <= r_tx[FRAME_BYTE_BITS-1];
                            r_tx   <= {r_tx[FRAME_BYTE_BITS-2:0], 1'b0};
                        end
                    end else if (w_cs_sync) begin
                        r_frame_error <= (r_bit_cnt != 3'd0);
                        r_miso        <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                DONE: begin
                    r_miso <= 1'b0;
                    if (w_cs_sync) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_spi_miso    = r_miso;
    assign bus.o_write_en    = r_write_en;
    assign bus.o_address     = r_address;
    assign bus.o_wdata       = r_wdata;
    assign bus.o_frame_error = r_frame_error;
endmodule
